// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router input/output stages.
// Contents: flit type codes, output port codes, input controller FSM states,
// and a helper locating the flit type field.
package noc_pkg;

  localparam int TYPE_W = 2;

  typedef enum logic [TYPE_W-1:0] {
    FT_HEADTAIL = 2'b00,
    FT_HEAD     = 2'b01,
    FT_BODY     = 2'b10,
    FT_TAIL     = 2'b11
  } flit_type_t;

  typedef enum logic [2:0] {
    PORT_N     = 3'd0,
    PORT_S     = 3'd1,
    PORT_W     = 3'd2,
    PORT_E     = 3'd3,
    PORT_LOCAL = 3'd4
  } port_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACTIVE
  } state_t;

  // Type field occupies the top TYPE_W bits of a flit.
  function automatic int type_lsb(input int flit_w);
    return flit_w - TYPE_W;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO, DEPTH a power of 2.
// Ports: clk, rst (sync, active-high), push/din write side, pop/dout read
// side (dout is the current head), full, empty.
// Push and pop may coincide at any occupancy; no write-to-read bypass.
module flit_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_input_port_ctrl.sv
// Per-input-port controller of the mesh wormhole router.
// Assembles phits into flits, buffers them, computes an XY route for each head
// flit, requests the switch allocator and forwards the packet once granted.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_valid/in_ready/in_phit         upstream phit stream
//   route_req/route_port/route_grant  switch allocator handshake
//   route_release                     pulse when the closing flit leaves
//   out_valid/out_ready/out_flit      flit stream toward the crossbar
//   err_pulse/err_count               protocol error pulse and saturating count
module noc_input_port_ctrl
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int PHIT_PER_FLIT = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int COORD_W       = 2,
  parameter int X_COORD       = 0,
  parameter int Y_COORD       = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               in_phit,
  output logic                                route_req,
  output logic [2:0]                          route_port,
  input  logic                                route_grant,
  output logic                                route_release,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH*PHIT_PER_FLIT-1:0] out_flit,
  output logic                                err_pulse,
  output logic [7:0]                          err_count
);

  localparam int FLIT_W   = DATA_WIDTH * PHIT_PER_FLIT;
  localparam int CNT_W    = (PHIT_PER_FLIT > 1) ? $clog2(PHIT_PER_FLIT) : 1;
  localparam int SLOT_W   = (PHIT_PER_FLIT > 1) ? (PHIT_PER_FLIT-1)*DATA_WIDTH : DATA_WIDTH;
  localparam int TYPE_LSB = type_lsb(FLIT_W);
  localparam logic [CNT_W-1:0] LAST_PHIT = CNT_W'(PHIT_PER_FLIT - 1);

  state_t             state;
  logic               first_flit;
  port_t              port_q;
  port_t              xy_port;
  logic [7:0]         err_cnt;
  logic [CNT_W-1:0]   phit_cnt;
  logic [SLOT_W-1:0]  partial;
  logic [FLIT_W-1:0]  push_flit;
  logic [FLIT_W-1:0]  head;
  logic               full;
  logic               empty;
  logic               handshake;
  logic               push;
  logic               pop;
  logic               release_now;
  logic               err_now;
  logic               head_is_start;
  flit_type_t         head_type;
  logic [COORD_W-1:0] dest_x;
  logic [COORD_W-1:0] dest_y;

  assign in_ready  = ~rst & ~full;
  assign handshake = in_valid & in_ready;
  assign push      = handshake & (phit_cnt == LAST_PHIT);

  // The final phit goes straight into the FIFO word; only earlier phits are held.
  if (PHIT_PER_FLIT > 1) begin : g_multi_phit
    assign push_flit = {in_phit, partial};
  end else begin : g_single_phit
    assign push_flit = in_phit;
  end

  flit_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_flit),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign head_type     = flit_type_t'(head[TYPE_LSB +: TYPE_W]);
  assign head_is_start = (head_type == FT_HEAD) | (head_type == FT_HEADTAIL);
  assign dest_x        = head[0 +: COORD_W];
  assign dest_y        = head[COORD_W +: COORD_W];

  always_comb begin
    if (dest_x > COORD_W'(X_COORD))      xy_port = PORT_E;
    else if (dest_x < COORD_W'(X_COORD)) xy_port = PORT_W;
    else if (dest_y > COORD_W'(Y_COORD)) xy_port = PORT_N;
    else if (dest_y < COORD_W'(Y_COORD)) xy_port = PORT_S;
    else                                 xy_port = PORT_LOCAL;
  end

  always_comb begin
    pop         = 1'b0;
    release_now = 1'b0;
    err_now     = 1'b0;
    case (state)
      ST_IDLE: begin
        // A packet cannot start with BODY/TAIL: discard it.
        if (!empty && !head_is_start) begin
          pop     = 1'b1;
          err_now = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!empty && out_ready) begin
          pop         = 1'b1;
          release_now = (head_type == FT_TAIL) | (head_type == FT_HEADTAIL);
          err_now     = ~first_flit & head_is_start;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      first_flit <= 1'b0;
      port_q     <= PORT_N;
      err_cnt    <= '0;
      phit_cnt   <= '0;
      partial    <= '0;
    end else begin
      if (handshake) begin
        if (phit_cnt == LAST_PHIT) begin
          phit_cnt <= '0;
        end else begin
          partial[int'(phit_cnt)*DATA_WIDTH +: DATA_WIDTH] <= in_phit;
          phit_cnt <= phit_cnt + 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (!empty && head_is_start) begin
            port_q <= xy_port;
            state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (route_grant) begin
            state      <= ST_ACTIVE;
            first_flit <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (pop) first_flit <= 1'b0;
          if (release_now) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (err_now && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
  end

  assign route_req     = ~rst & (state == ST_REQ);
  assign route_port    = rst ? '0 : port_q;
  assign route_release = ~rst & release_now;
  assign out_valid     = ~rst & (state == ST_ACTIVE) & ~empty;
  assign out_flit      = rst ? '0 : head;
  assign err_pulse     = ~rst & err_now;
  assign err_count     = rst ? '0 : err_cnt;

endmodule

// File: tb/tb_noc_input_port_ctrl.sv
// Self-checking bench for noc_input_port_ctrl (router at X=1, Y=1, two phits
// per flit). A packet-level model derives, from the accepted phit stream,
// the expected route requests, forwarded flits with their release flags,
// and the protocol error count. Directed sections check latency, flow
// control and reset; a randomized section mixes packet shapes and errors.
module tb_noc_input_port_ctrl;

  localparam int DW = 8;
  localparam int XC = 1;
  localparam int YC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_phit = '0;
  logic        route_req;
  logic [2:0]  route_port;
  logic        route_grant = 1'b0;
  logic        route_release;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_flit;
  logic        err_pulse;
  logic [7:0]  err_count;

  noc_input_port_ctrl #(
    .DATA_WIDTH    (DW),
    .PHIT_PER_FLIT (2),
    .FIFO_DEPTH    (4),
    .COORD_W       (2),
    .X_COORD       (XC),
    .Y_COORD       (YC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_phit       (in_phit),
    .route_req     (route_req),
    .route_port    (route_port),
    .route_grant   (route_grant),
    .route_release (route_release),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_flit      (out_flit),
    .err_pulse     (err_pulse),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- packet-level reference model ----------------
  logic [16:0] exp_out[$];   // {closes_packet, flit}
  logic [2:0]  exp_ports[$];
  int          exp_err = 0;
  int          seen_err = 0;
  bit          open_pkt = 0;
  logic [7:0]  phit_hold = '0;
  int          phit_idx = 0;
  int          acc_phits = 0;

  function automatic logic [2:0] xy_ref(input logic [15:0] f);
    int dx = int'(f[1:0]);
    int dy = int'(f[3:2]);
    if (dx > XC) return 3'd3;
    if (dx < XC) return 3'd2;
    if (dy > YC) return 3'd0;
    if (dy < YC) return 3'd1;
    return 3'd4;
  endfunction

  task automatic model_flit(input logic [15:0] f);
    logic [1:0] t = f[15:14];
    bit is_head = (t == 2'b00) || (t == 2'b01);
    bit closes  = (t == 2'b00) || (t == 2'b11);
    if (!open_pkt) begin
      if (!is_head) exp_err++;
      else begin
        exp_ports.push_back(xy_ref(f));
        exp_out.push_back({closes, f});
        open_pkt = !closes;
      end
    end else begin
      exp_out.push_back({closes, f});
      if (is_head) exp_err++;
      if (closes) open_pkt = 0;
    end
  endtask

  task automatic model_phit(input logic [7:0] p);
    acc_phits++;
    if (phit_idx == 0) begin
      phit_hold = p;
      phit_idx  = 1;
    end else begin
      phit_idx = 0;
      model_flit({p, phit_hold});
    end
  endtask

  // ---------------- drivers ----------------
  bit grant_rand = 0;
  bit ready_rand = 0;
  bit mon_en = 0;
  bit sender_done = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (grant_rand) route_grant = ($urandom_range(0, 2) == 0);
      if (ready_rand) out_ready   = ($urandom_range(0, 3) != 0);
    end
  end

  // Drives one phit; starts just after a rising edge so no handshake is missed.
  task automatic send_phit(input logic [7:0] p);
    int n = 0;
    bit ok = 1;
    if (($time % 10) != 6) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_phit  = p;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 300) begin
        check_eq("send_timeout", 32'(in_ready), 32'd1);
        ok = 0;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (ok) model_phit(p);
  endtask

  task automatic send_flit(input logic [1:0] t, input logic [1:0] dx, input logic [1:0] dy);
    send_phit({4'($urandom_range(0, 15)), dy, dx});
    send_phit({t, 6'($urandom_range(0, 63))});
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    forever begin
      @(negedge clk);
      if (route_req) break;
      if (++n > 100) begin
        check_eq({tag, "_req_timeout"}, 32'(route_req), 32'd1);
        break;
      end
    end
  endtask

  task automatic grant_now();
    route_grant = 1'b1;
    @(posedge clk);
    #1;
    route_grant = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_out.size() != 0 || exp_ports.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_drained"}, 32'(exp_out.size() + exp_ports.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_route_req"}, 32'(route_req), 32'd0);
    check_eq({tag, "_route_port"}, 32'(route_port), 32'd0);
    check_eq({tag, "_release"}, 32'(route_release), 32'd0);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_out_flit"}, 32'(out_flit), 32'd0);
    check_eq({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
    check_eq({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    mon_en   = 0;
    rst      = 1'b1;
    @(negedge clk);
    check_zero(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_out.delete();
    exp_ports.delete();
    open_pkt = 0;
    phit_idx = 0;
    exp_err  = 0;
    seen_err = 0;
    mon_en   = 1;
  endtask

  // ---------------- monitor ----------------
  logic       mon_req_prev = 1'b0;
  logic [2:0] mon_held = '0;
  logic [16:0] mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        mon_req_prev = 1'b0;
      end else begin
        if (err_pulse) seen_err++;
        if (route_req) begin
          check_eq("req_no_out", 32'(out_valid), 32'd0);
          if (!mon_req_prev) begin
            if (exp_ports.size() == 0) check_eq("unexp_req", 32'(route_req), 32'd0);
            else check_eq("req_port", 32'(route_port), 32'(exp_ports.pop_front()));
            mon_held = route_port;
          end else begin
            check_eq("req_port_stable", 32'(route_port), 32'(mon_held));
          end
        end
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) check_eq("unexp_out", 32'(out_valid), 32'd0);
          else begin
            mon_e = exp_out.pop_front();
            check_eq("out_flit", 32'(out_flit), 32'(mon_e[15:0]));
            check_eq("release", 32'(route_release), 32'(mon_e[16]));
          end
        end else if (route_release) begin
          check_eq("stray_release", 32'(route_release), 32'd0);
        end
        mon_req_prev = route_req;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [7:0] stream [10];

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1;

    // Single-flit packet to (1,2): route N two cycles after the last phit
    out_ready = 1'b1;
    send_phit(8'h09);
    send_phit(8'h00);
    @(negedge clk);
    check_eq("t1_req_early", 32'(route_req), 32'd0);
    @(negedge clk);
    check_eq("t1_req", 32'(route_req), 32'd1);
    check_eq("t1_port", 32'(route_port), 32'd0);
    grant_now();
    @(negedge clk);
    check_eq("t1_out_valid", 32'(out_valid), 32'd1);
    check_eq("t1_out_flit", 32'(out_flit), 32'h0009);
    check_eq("t1_release", 32'(route_release), 32'd1);
    @(negedge clk);
    check_eq("t1_out_done", 32'(out_valid), 32'd0);
    check_eq("t1_req_done", 32'(route_req), 32'd0);

    // Four-flit packet to (3,1): route E, four back-to-back flits
    send_phit(8'h07); send_phit(8'h40);
    send_phit(8'h11); send_phit(8'h80);
    send_phit(8'h22); send_phit(8'h95);
    send_phit(8'h33); send_phit(8'hC0);
    wait_req("t2");
    check_eq("t2_port", 32'(route_port), 32'd3);
    grant_now();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t2_valid", 32'(out_valid), 32'd1);
      check_eq("t2_release", 32'(route_release), 32'(i == 3));
    end
    @(negedge clk);
    check_eq("t2_idle_valid", 32'(out_valid), 32'd0);
    check_eq("t2_idle_req", 32'(route_req), 32'd0);

    // Backpressure: head forwarded, then stall and stream 10 phits
    send_phit(8'h00); send_phit(8'h40);
    wait_req("t3");
    grant_now();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      stream[2*k]   = 8'(k*3 + 1);
      stream[2*k+1] = {2'b10, 6'(k)};
    end
    stream[8] = 8'h5A;
    stream[9] = 8'hC1;
    acc_phits   = 0;
    sender_done = 0;
    fork
      begin
        for (int k = 0; k < 10; k++) send_phit(stream[k]);
        sender_done = 1;
      end
    join_none
    repeat (20) @(negedge clk);
    check_eq("t3_accepted", 32'(acc_phits), 32'd8);
    check_eq("t3_in_ready_low", 32'(in_ready), 32'd0);
    check_eq("t3_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("t3_in_ready_popcyc", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_eq("t3_in_ready_back", 32'(in_ready), 32'd1);
    for (int n = 0; n < 200 && !sender_done; n++) @(negedge clk);
    check_eq("t3_sender_done", 32'(sender_done), 32'd1);
    drain("t3");

    // Stray BODY while idle, then a normal single-flit packet to Local
    send_phit(8'h00); send_phit(8'h80);
    repeat (4) @(negedge clk);
    check_eq("t4_err_count", 32'(err_count), 32'(exp_err));
    check_eq("t4_err_one", 32'(err_count), 32'd1);
    check_eq("t4_err_seen", 32'(seen_err), 32'(exp_err));
    check_eq("t4_no_req", 32'(route_req), 32'd0);
    send_phit(8'h05); send_phit(8'h00);
    wait_req("t4");
    check_eq("t4_port", 32'(route_port), 32'd4);
    grant_now();
    drain("t4");

    // Grant withheld for five cycles: request and port held, nothing moves
    send_phit(8'h04); send_phit(8'h00);
    wait_req("t5");
    for (int i = 0; i < 5; i++) begin
      check_eq("t5_req_held", 32'(route_req), 32'd1);
      check_eq("t5_port_held", 32'(route_port), 32'd2);
      check_eq("t5_no_out", 32'(out_valid), 32'd0);
      if (i < 4) @(negedge clk);
    end
    grant_now();
    drain("t5");

    // Reset after one phit, and reset mid-packet in ACTIVE
    send_phit(8'h05);
    do_reset("t6a");
    send_phit(8'h07); send_phit(8'h40);
    send_phit(8'h12); send_phit(8'h80);
    wait_req("t6");
    grant_now();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    do_reset("t6b");
    out_ready = 1'b1;
    send_phit(8'h02); send_phit(8'h00);
    wait_req("t6c");
    check_eq("t6_port", 32'(route_port), 32'd3);
    grant_now();
    @(negedge clk);
    check_eq("t6_out_flit", 32'(out_flit), 32'h0002);
    check_eq("t6_release", 32'(route_release), 32'd1);
    drain("t6");

    // Randomized packets, stray flits, misplaced heads, random grant/ready
    grant_rand = 1;
    ready_rand = 1;
    for (int pkt = 0; pkt < 40; pkt++) begin
      logic [1:0] dx;
      logic [1:0] dy;
      int len;
      dx = 2'($urandom_range(0, 3));
      dy = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        send_flit(($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11, dx, dy);
      end else begin
        len = $urandom_range(1, 4);
        if (len == 1) send_flit(2'b00, dx, dy);
        else begin
          send_flit(2'b01, dx, dy);
          for (int b = 0; b < len - 2; b++)
            send_flit(($urandom_range(0, 7) == 0) ? 2'b01 : 2'b10, dx, dy);
          send_flit(2'b11, dx, dy);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain("rand");
    grant_rand = 0;
    ready_rand = 0;
    @(posedge clk);
    #1;
    route_grant = 1'b0;
    out_ready   = 1'b1;

    check_eq("final_err_count", 32'(err_count), 32'((exp_err > 255) ? 255 : exp_err));
    check_eq("final_err_seen", 32'(seen_err), 32'(exp_err));
    check_eq("final_idle_req", 32'(route_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
